// File: rtl/icache_pkg.sv
// Shared constants, address-split helpers and state encoding for the
// direct-mapped, one-word-per-line instruction cache.
package icache_pkg;

  localparam int ICACHE_LINES = 256;
  localparam int INST_SIZE    = 32;
  localparam int IDX_W        = 8;
  localparam int TAG_W        = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_DONE = 2'd2
  } icache_state_e;

  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return pc[9:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:10];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface icache_if;
  logic        if_en_i;
  logic [31:0] if_addr_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_en_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  if_en_i, if_addr_i, mem_en_i, mem_data_i,
    output if_valid_o, if_inst_o, mem_en_o, mem_addr_o
  );

  modport master (
    output if_en_i, if_addr_i, mem_en_i, mem_data_i,
    input  if_valid_o, if_inst_o, mem_en_o, mem_addr_o
  );
endinterface

// File: rtl/icache_array.sv
// Tag/data store with one combinational read port and one write port.
// Only the valid vector is reset; tag/data contents are gated by it.
module icache_array
  import icache_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic                 o_rd_valid,
  output logic [TAG_W-1:0]     o_rd_tag,
  output logic [INST_SIZE-1:0] o_rd_data,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [TAG_W-1:0]     i_wr_tag,
  input  logic [INST_SIZE-1:0] i_wr_data
);

  logic [ICACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [INST_SIZE-1:0]    r_data [ICACHE_LINES];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: IDLE lookup, MISS refill with data
// forwarding, DONE bubble before the next lookup.
module icache
  import icache_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear,
  icache_if.slave  bus
);

  icache_state_e        r_state;
  logic                 r_valid_o;
  logic [31:0]          r_inst_o;
  logic                 r_mem_en_o;
  logic [31:0]          r_mem_addr_o;

  logic                 w_rd_valid;
  logic [TAG_W-1:0]     w_rd_tag;
  logic [INST_SIZE-1:0] w_rd_data;
  logic                 w_hit;
  logic                 w_we;
  logic                 w_unused;

  // Low PC bits only select bytes within the word and are ignored.
  assign w_unused = ^bus.if_addr_i[1:0];

  assign w_hit = w_rd_valid && (w_rd_tag == pc_tag(bus.if_addr_i));
  assign w_we  = rdy_in && !clear && (r_state == ST_MISS) && bus.mem_en_i;

  icache_array u_array (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_rd_idx   (pc_idx(bus.if_addr_i)),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_idx   (pc_idx(r_mem_addr_o)),
    .i_wr_tag   (pc_tag(r_mem_addr_o)),
    .i_wr_data  (bus.mem_data_i)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_valid_o    <= 1'b0;
      r_inst_o     <= '0;
      r_mem_en_o   <= 1'b0;
      r_mem_addr_o <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_state    <= ST_IDLE;
        r_valid_o  <= 1'b0;
        r_mem_en_o <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_valid_o <= 1'b0;
            if (bus.if_en_i) begin
              if (w_hit) begin
                r_valid_o <= 1'b1;
                r_inst_o  <= w_rd_data;
                r_state   <= ST_DONE;
              end else begin
                r_mem_en_o   <= 1'b1;
                r_mem_addr_o <= {bus.if_addr_i[31:2], 2'b00};
                r_state      <= ST_MISS;
              end
            end
          end
          ST_MISS: begin
            if (bus.mem_en_i) begin
              r_mem_en_o <= 1'b0;
              r_valid_o  <= 1'b1;
              r_inst_o   <= bus.mem_data_i;
              r_state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_valid_o <= 1'b0;
            r_state   <= ST_IDLE;
          end
          default: begin
            r_valid_o  <= 1'b0;
            r_mem_en_o <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.if_valid_o = r_valid_o;
  assign bus.if_inst_o  = r_inst_o;
  assign bus.mem_en_o   = r_mem_en_o;
  assign bus.mem_addr_o = r_mem_addr_o;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: refill, hit, conflict replacement, clear,
// rdy_in stall and asynchronous reset mid-refill.
module tb_icache;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  icache_if bus ();

  icache dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Miss with a two-cycle memory latency, then refill.
  task automatic fetch_miss(input string tag, input logic [31:0] pc, input logic [31:0] word);
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = pc;
    tick();
    chk({tag, "_mem_en"}, {31'd0, bus.mem_en_o}, 32'd1);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, {pc[31:2], 2'b00});
    chk({tag, "_no_valid"}, {31'd0, bus.if_valid_o}, 32'd0);
    tick();
    chk({tag, "_mem_en_held"}, {31'd0, bus.mem_en_o}, 32'd1);
    bus.mem_en_i   = 1'b1;
    bus.mem_data_i = word;
    tick();
    bus.mem_en_i   = 1'b0;
    bus.mem_data_i = 32'h0;
    bus.if_en_i    = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus.if_valid_o}, 32'd1);
    chk({tag, "_inst"}, bus.if_inst_o, word);
    chk({tag, "_mem_en_drop"}, {31'd0, bus.mem_en_o}, 32'd0);
    tick();
    chk({tag, "_bubble"}, {31'd0, bus.if_valid_o}, 32'd0);
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] pc, input logic [31:0] word);
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = pc;
    tick();
    bus.if_en_i = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus.if_valid_o}, 32'd1);
    chk({tag, "_inst"}, bus.if_inst_o, word);
    chk({tag, "_no_mem"}, {31'd0, bus.mem_en_o}, 32'd0);
    tick();
    chk({tag, "_bubble"}, {31'd0, bus.if_valid_o}, 32'd0);
  endtask

  initial begin
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    clear          = 1'b0;
    bus.if_en_i    = 1'b0;
    bus.if_addr_i  = 32'h0;
    bus.mem_en_i   = 1'b0;
    bus.mem_data_i = 32'h0;
    #12;
    chk("rst_valid", {31'd0, bus.if_valid_o}, 32'd0);
    chk("rst_inst", bus.if_inst_o, 32'h0);
    chk("rst_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    rst_in = 1'b1;
    tick();

    fetch_miss("m0", 32'h0000_0000, 32'h0000_0013);
    fetch_hit("h0", 32'h0000_0000, 32'h0000_0013);
    fetch_miss("m400", 32'h0000_0400, 32'h0010_0093);
    fetch_hit("h400", 32'h0000_0400, 32'h0010_0093);
    fetch_miss("m0b", 32'h0000_0000, 32'h0000_0013);

    // Refill pulse collides with clear: no delivery, no array write.
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0008;
    tick();
    chk("clr_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    chk("clr_mem_addr", bus.mem_addr_o, 32'h0000_0008);
    clear          = 1'b1;
    bus.mem_en_i   = 1'b1;
    bus.mem_data_i = 32'hDEAD_BEEF;
    bus.if_en_i    = 1'b0;
    tick();
    clear        = 1'b0;
    bus.mem_en_i = 1'b0;
    chk("clr_no_valid", {31'd0, bus.if_valid_o}, 32'd0);
    chk("clr_mem_en_drop", {31'd0, bus.mem_en_o}, 32'd0);
    tick();
    chk("clr_no_valid2", {31'd0, bus.if_valid_o}, 32'd0);
    fetch_miss("m8", 32'h0000_0008, 32'h1111_2222);

    // Clear alongside a would-be hit in IDLE drops that cycle's request.
    clear         = 1'b1;
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0008;
    tick();
    clear = 1'b0;
    chk("clr_req_ignored", {31'd0, bus.if_valid_o}, 32'd0);
    fetch_hit("h8_after_clr", 32'h0000_0008, 32'h1111_2222);

    // rdy_in low during MISS freezes the request.
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0013;
    tick();
    chk("stall_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    chk("stall_mem_addr", bus.mem_addr_o, 32'h0000_0010);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_en", {31'd0, bus.mem_en_o}, 32'd1);
      chk("stall_hold_addr", bus.mem_addr_o, 32'h0000_0010);
      chk("stall_no_valid", {31'd0, bus.if_valid_o}, 32'd0);
    end
    rdy_in         = 1'b1;
    bus.mem_en_i   = 1'b1;
    bus.mem_data_i = 32'h0040_0513;
    tick();
    bus.mem_en_i = 1'b0;
    bus.if_en_i  = 1'b0;
    chk("stall_valid", {31'd0, bus.if_valid_o}, 32'd1);
    chk("stall_inst", bus.if_inst_o, 32'h0040_0513);
    tick();
    fetch_hit("h10", 32'h0000_0010, 32'h0040_0513);

    // Asynchronous reset in the middle of a refill.
    bus.if_en_i   = 1'b1;
    bus.if_addr_i = 32'h0000_0020;
    tick();
    chk("ar_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    bus.if_en_i = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("ar_mem_en_zero", {31'd0, bus.mem_en_o}, 32'd0);
    chk("ar_mem_addr_zero", bus.mem_addr_o, 32'h0);
    chk("ar_inst_zero", bus.if_inst_o, 32'h0);
    chk("ar_valid_zero", {31'd0, bus.if_valid_o}, 32'd0);
    #1 rst_in = 1'b1;
    tick();
    bus.mem_en_i   = 1'b1;
    bus.mem_data_i = 32'h5555_AAAA;
    tick();
    bus.mem_en_i = 1'b0;
    chk("stray_no_valid", {31'd0, bus.if_valid_o}, 32'd0);
    chk("stray_no_mem", {31'd0, bus.mem_en_o}, 32'd0);
    fetch_miss("m0_after_rst", 32'h0000_0000, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameters: none; sizes come from def.v constants ICacheLines = 256, one 32-bit word per line, direct-mapped.
REQ-002 clk_in  input  1  sole clock, rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-005 clear  input  1  pipeline flush (branch mispredict); synchronous.
REQ-006 if_en_i  input  1  fetch request from IF stage.
REQ-007 if_addr_i  input  32  fetch PC; bits [1:0] ignored.
REQ-008 if_valid_o  output  1  one-cycle pulse: if_inst_o valid for current request.
REQ-009 if_inst_o  output  32  fetched instruction.
REQ-010 mem_en_o  output  1  refill request to memory controller, level, held until answered.
REQ-011 mem_addr_o  output  32  refill word address, {pc[31:2],2'b00}.
REQ-012 mem_en_i  input  1  one-cycle refill-done pulse from memory controller.
REQ-013 mem_data_i  input  32  refill word, valid when mem_en_i = 1.

Function
REQ-014 Address split: index = pc[9:2], tag = pc[31:10]; 256 entries of {valid, tag[21:0], data[31:0]}.
REQ-015 States: IDLE, MISS, DONE.
REQ-016 IDLE, if_en_i = 1, hit (valid and tag match): next cycle if_valid_o = 1, if_inst_o = stored data, state -> DONE.
REQ-017 IDLE, if_en_i = 1, miss: next cycle mem_en_o = 1, mem_addr_o = aligned pc, state -> MISS.
REQ-018 MISS: mem_en_o held at 1 and mem_addr_o held stable until mem_en_i sampled high.
REQ-019 MISS, mem_en_i = 1: write {1, tag, mem_data_i} to the indexed entry; next cycle mem_en_o = 0, if_valid_o = 1, if_inst_o = mem_data_i (forwarded), state -> DONE.
REQ-020 DONE: if_valid_o cleared, state -> IDLE; no lookup in this cycle (one bubble per fetch; it covers the memory controller's one-cycle post-transfer wait state).
REQ-021 Hit latency: 1 cycle after request sampled; miss latency: memory controller latency + 1 cycle.
REQ-022 IF stage holds if_en_i and if_addr_i stable from request until if_valid_o; the cache samples the address in IDLE only.
REQ-023 if_valid_o is never high for two consecutive cycles.
REQ-024 clear = 1 (any state): state -> IDLE, mem_en_o = 0, if_valid_o = 0 next cycle; array contents and valid bits retained.
REQ-025 clear = 1 in the same cycle as mem_en_i = 1: clear wins, entry not written, no if_valid_o.
REQ-026 clear = 1 with if_en_i = 1 in IDLE: request ignored that cycle.
REQ-027 rdy_in = 0: no state, array or output change; a mem_en_i pulse is not expected while rdy_in = 0.
REQ-028 Array write and read of the same index in one cycle cannot occur (DONE bubble); no bypass beyond REQ-019 is needed.

Reset
REQ-029 On rst_in = 0 (asynchronous): state = IDLE, if_valid_o = 0, if_inst_o = 0, mem_en_o = 0, mem_addr_o = 0, all 256 valid bits = 0.
REQ-030 Tag/data storage is not reset; valid bits gate its use.
REQ-031 Reset asserted mid-refill abandons the refill; a later stray mem_en_i in IDLE is ignored.

Structure
REQ-032 def.v holds ICacheLines, index/tag bit-range macros, the InstSize macro and the icache state encodings.
REQ-033 One sub-module, icache_array: 256-entry tag/data store, one read port and one write port, plus the valid-bit vector with asynchronous reset.

Verification
REQ-034 After reset, fetch pc 0x00000000 -> mem_en_o = 1, mem_addr_o = 0x0; mem_en_i with 0x00000013 -> next cycle if_valid_o = 1, if_inst_o = 0x00000013.
REQ-035 Repeat fetch 0x00000000 -> if_valid_o = 1 exactly 1 cycle after the request, mem_en_o stays 0.
REQ-036 Fetch 0x00000400 (same index 0, different tag) -> miss, mem_addr_o = 0x400, refill 0x00100093 -> entry replaced; then fetch 0x0 -> miss again.
REQ-037 Miss on 0x00000008, clear in the same cycle as mem_en_i = 0xDEADBEEF -> no if_valid_o; re-fetch 0x8 -> miss.
REQ-038 rdy_in = 0 for 3 cycles during MISS -> mem_en_o and mem_addr_o unchanged; completes normally afterwards.
REQ-039 Assert rst_in = 0 mid-refill -> all outputs 0 immediately; fetch of the previously cached pc 0x0 -> miss.
